// File: rtl/cpu_gen.sv
// cpu_gen: parametrised accumulator CPU with fetch-valid stall, Z/C flags and branches.
// Define CPU_GEN_CALL_EN to add the SD-entry circular CALL/RET return stack.
module cpu_gen #(
    parameter int DW = 4,
    parameter int AW = 4,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] btn,
    output logic [DW-1:0] led,
    output logic [AW-1:0] imem_addr,
    input  logic [AW+4:0] imem_data,
    input  logic          imem_valid,
    output logic          c_flag,
    output logic          z_flag,
    output logic          halted
);

    if (DW < 2 || AW < 3 || SD < 1) begin : g_bad_params
        $error("cpu_gen: needs DW >= 2, AW >= 3, SD >= 1");
    end

    localparam logic [4:0] OP_ADD = 5'b01000, OP_OR  = 5'b01001, OP_AND = 5'b01010,
                           OP_XOR = 5'b01011, OP_INC = 5'b01100, OP_NOT = 5'b01101,
                           OP_SHR = 5'b01110, OP_SHL = 5'b01111, OP_JNC = 5'b10000,
                           OP_JC  = 5'b10001, OP_JZ  = 5'b10010, OP_JNZ = 5'b10011,
                           OP_JMP = 5'b10100, OP_SET = 5'b10101, OP_SUB = 5'b10110,
                           OP_HLT = 5'b10111;

    logic [DW-1:0] regs [8];
    logic [AW-1:0] pc, pc_inc, pc_next;
    logic [4:0]    op;
    logic [AW-1:0] f;
    logic [DW-1:0] rs, r0, imm;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] wr_data;
    logic [2:0]    wr_sel;
    logic          wr_en, z_en, c_en, c_new, z_new, halt_next;
    logic          retire;

    assign op        = imem_data[AW+4:AW];
    assign f         = imem_data[AW-1:0];
    assign rs        = regs[f[2:0]];
    assign r0        = regs[0];
    assign imm       = DW'(f);
    assign pc_inc    = pc + AW'(1);
    assign retire    = imem_valid && !halted;
    assign imem_addr = pc;
    assign led       = regs[6];

`ifdef CPU_GEN_CALL_EN
    localparam int SW = (SD > 1) ? $clog2(SD) : 1;
    localparam int CW = $clog2(SD + 1);

    logic [AW-1:0] stack_mem [SD];
    logic [SW-1:0] sp, top_idx;
    logic [CW-1:0] cnt;
    logic          push, pop;

    // sp is the next free slot; the newest entry sits just below it, circularly.
    assign top_idx = (sp == '0) ? SW'(SD - 1) : sp - SW'(1);
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        wr_en     = 1'b0;
        wr_sel    = 3'd0;
        wr_data   = '0;
        alu_wide  = '0;
        z_en      = 1'b0;
        c_en      = 1'b0;
        c_new     = c_flag;
        halt_next = 1'b0;
        pc_next   = pc_inc;
`ifdef CPU_GEN_CALL_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        casez (op)
            5'b00???: begin wr_en = 1'b1; wr_sel = op[2:0]; wr_data = rs; end
            OP_ADD: begin
                alu_wide = {1'b0, r0} + {1'b0, rs};
                wr_data = alu_wide[DW-1:0]; c_new = alu_wide[DW];
                wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
            end
            OP_SUB: begin
                alu_wide = {1'b0, r0} - {1'b0, rs};
                wr_data = alu_wide[DW-1:0]; c_new = alu_wide[DW];
                wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
            end
            OP_INC: begin
                alu_wide = {1'b0, rs} + (DW+1)'(1);
                wr_data = alu_wide[DW-1:0]; c_new = alu_wide[DW]; wr_sel = f[2:0];
                wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
            end
            OP_SHR: begin
                wr_data = rs >> 1; c_new = rs[0]; wr_sel = f[2:0];
                wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
            end
            OP_SHL: begin
                wr_data = rs << 1; c_new = rs[DW-1]; wr_sel = f[2:0];
                wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
            end
            OP_OR:  begin wr_data = r0 | rs; wr_en = 1'b1; z_en = 1'b1; end
            OP_AND: begin wr_data = r0 & rs; wr_en = 1'b1; z_en = 1'b1; end
            OP_XOR: begin wr_data = r0 ^ rs; wr_en = 1'b1; z_en = 1'b1; end
            OP_NOT: begin wr_data = ~rs; wr_sel = f[2:0]; wr_en = 1'b1; z_en = 1'b1; end
            OP_SET: begin wr_data = imm; wr_en = 1'b1; z_en = 1'b1; end
            OP_JNC: pc_next = c_flag ? pc_inc : f;
            OP_JC:  pc_next = c_flag ? f : pc_inc;
            OP_JZ:  pc_next = z_flag ? f : pc_inc;
            OP_JNZ: pc_next = z_flag ? pc_inc : f;
            OP_JMP: pc_next = f;
            OP_HLT: begin halt_next = 1'b1; pc_next = pc; end
`ifdef CPU_GEN_CALL_EN
            5'b11000: begin push = 1'b1; pc_next = f; end
            5'b11001: if (cnt != '0) begin pop = 1'b1; pc_next = stack_mem[top_idx]; end
`endif
            default: ;
        endcase
        z_new = (wr_data == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            pc     <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            halted <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every read see pre-edge values, so rs == rd is safe.
            if (retire) begin
                if (wr_en) regs[wr_sel] <= wr_data;
                if (z_en)  z_flag <= z_new;
                if (c_en)  c_flag <= c_new;
                pc     <= pc_next;
                halted <= halt_next;
            end
            // Placed last so it overrides any instruction write to r5.
            regs[5] <= btn;
        end
    end

`ifdef CPU_GEN_CALL_EN
    // NOTE: stack_mem is deliberately not reset; clearing cnt makes its stale contents unreachable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp  <= '0;
            cnt <= '0;
        end else if (retire) begin
            if (push) begin
                stack_mem[sp] <= pc_inc;
                sp <= (sp == SW'(SD - 1)) ? '0 : sp + SW'(1);
                if (cnt != CW'(SD)) cnt <= cnt + CW'(1);
            end else if (pop) begin
                sp  <= top_idx;
                cnt <= cnt - CW'(1);
            end
        end
    end
`endif

endmodule
